// File: rtl/console_host.sv
// Wishbone master that polls the console FIFO status, drains RX characters and pushes TX characters.
// Optional ack watchdog: define CONSOLE_HOST_TIMEOUT_EN.
module console_host #(
    parameter int POLL_INTERVAL = 16,
    parameter int TIMEOUT       = 15
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [1:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    input  logic        i_tx_stb,
    input  logic [6:0]  i_tx_data,
    output logic        o_tx_busy,
    output logic        o_rx_stb,
    output logic [6:0]  o_rx_data,
    input  logic        i_rx_busy,
    output logic        o_rx_err,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {S_WAIT, S_POLL, S_RXREAD, S_TXWRITE} state_t;

    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_RX   = 2'b10;
    localparam logic [1:0] ADDR_TX   = 2'b11;

    state_t      state_q, state_d, go_state;
    logic [7:0]  cnt_q, cnt_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic        rx_avail_q, rx_avail_d, tx_room_q, tx_room_d;
    logic        tx_full_q, tx_full_d, rx_full_q, rx_full_d;
    logic [6:0]  tx_char_q, tx_char_d, rx_char_q, rx_char_d;
    logic        rx_err_q, rx_err_d, bus_err_q, bus_err_d;
    logic        go, ack, err, tmo, rx_pop;
    logic        unused_bits;

`ifdef CONSOLE_HOST_TIMEOUT_EN
    logic [3:0]  tmr_q, tmr_d;
    assign tmo = cyc_q && (tmr_q == 4'd0) && !i_wb_ack && !i_wb_err;
    assign unused_bits = ^{i_wb_data[31:17], i_wb_data[15:13], i_wb_data[11:9], i_wb_data[7]};
`else
    assign tmo = 1'b0;
    assign unused_bits = ^{i_wb_data[31:17], i_wb_data[15:13], i_wb_data[11:9], i_wb_data[7],
                           1'(TIMEOUT)};
`endif

    assign ack    = cyc_q && i_wb_ack;
    assign err    = cyc_q && i_wb_err;
    assign rx_pop = rx_full_q && !i_rx_busy;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q && i_wb_stall;
        we_d       = we_q;
        addr_d     = addr_q;
        rx_avail_d = rx_avail_q;
        tx_room_d  = tx_room_q;
        tx_full_d  = tx_full_q;
        tx_char_d  = tx_char_q;
        rx_full_d  = rx_full_q;
        rx_char_d  = rx_char_q;
        rx_err_d   = 1'b0;
        bus_err_d  = 1'b0;
        go         = 1'b0;
        go_state   = S_POLL;
`ifdef CONSOLE_HOST_TIMEOUT_EN
        tmr_d      = (cyc_q && tmr_q != 4'd0) ? tmr_q - 4'd1 : tmr_q;
`endif

        if (i_tx_stb && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_char_d = i_tx_data;
        end
        if (rx_pop)
            rx_full_d = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    go       = 1'b1;
                    go_state = S_POLL;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                if (cyc_q) begin
                    if (err || tmo) begin
                        cyc_d     = 1'b0;
                        stb_d     = 1'b0;
                        we_d      = 1'b0;
                        bus_err_d = 1'b1;
                        state_d   = S_WAIT;
                        cnt_d     = 8'(POLL_INTERVAL);
                    end else if (ack) begin
                        cyc_d = 1'b0;
                        stb_d = 1'b0;
                        we_d  = 1'b0;
                        if (state_q == S_POLL) begin
                            rx_avail_d = i_wb_data[0];
                            tx_room_d  = i_wb_data[16];
                        end else if (state_q == S_RXREAD) begin
                            // Load after the pop above so a same-edge pop and load keeps the new char.
                            if (!i_wb_data[8]) begin
                                rx_full_d = 1'b1;
                                rx_char_d = i_wb_data[6:0];
                            end
                            rx_err_d = i_wb_data[12];
                        end else begin
                            tx_full_d = 1'b0;
                        end
                    end
                end else begin
                    // Idle gap after the ack: choose the next transaction.
                    if (state_q == S_POLL && rx_avail_q && (!rx_full_q || rx_pop)) begin
                        go       = 1'b1;
                        go_state = S_RXREAD;
                    end else if (state_q != S_TXWRITE && tx_room_q && tx_full_q) begin
                        go       = 1'b1;
                        go_state = S_TXWRITE;
                    end else if (state_q == S_POLL) begin
                        state_d = S_WAIT;
                        cnt_d   = 8'(POLL_INTERVAL);
                    end else begin
                        go       = 1'b1;
                        go_state = S_POLL;
                    end
                end
            end
        endcase

        if (go) begin
            state_d = go_state;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = (go_state == S_TXWRITE);
            addr_d  = (go_state == S_POLL) ? ADDR_STAT :
                      (go_state == S_RXREAD) ? ADDR_RX : ADDR_TX;
`ifdef CONSOLE_HOST_TIMEOUT_EN
            tmr_d   = 4'(TIMEOUT - 1);
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_WAIT;
            cnt_q      <= 8'd0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 2'b00;
            rx_avail_q <= 1'b0;
            tx_room_q  <= 1'b0;
            tx_full_q  <= 1'b0;
            tx_char_q  <= 7'd0;
            rx_full_q  <= 1'b0;
            rx_char_q  <= 7'd0;
            rx_err_q   <= 1'b0;
            bus_err_q  <= 1'b0;
`ifdef CONSOLE_HOST_TIMEOUT_EN
            tmr_q      <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            rx_avail_q <= rx_avail_d;
            tx_room_q  <= tx_room_d;
            tx_full_q  <= tx_full_d;
            tx_char_q  <= tx_char_d;
            rx_full_q  <= rx_full_d;
            rx_char_q  <= rx_char_d;
            rx_err_q   <= rx_err_d;
            bus_err_q  <= bus_err_d;
`ifdef CONSOLE_HOST_TIMEOUT_EN
            tmr_q      <= tmr_d;
`endif
        end
    end

    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = we_q;
    assign o_wb_addr = addr_q;
    assign o_wb_data = we_q ? {25'h0, tx_char_q} : 32'h0;
    assign o_tx_busy = tx_full_q;
    assign o_rx_stb  = rx_full_q;
    assign o_rx_data = rx_char_q;
    assign o_rx_err  = rx_err_q;
    assign o_bus_err = bus_err_q;

endmodule

// File: tb/tb_console_host.sv
// Self-checking bench for console_host: models a 2-cycle-ack console slave and checks
// transaction order, timing and holding-register behaviour against expectations from the console rules.
module tb_console_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_ack = 1'b0, wb_err = 1'b0;
    logic [31:0] wb_rdata = 32'h0;
    logic        tx_stb;
    logic [6:0]  tx_data;
    logic        tx_busy, rx_stb, rx_err, bus_err;
    logic [6:0]  rx_data;
    logic        rx_busy;

    always #5 clk = ~clk;

    console_host #(.POLL_INTERVAL(16), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_data(wb_wdata), .i_wb_ack(wb_ack), .i_wb_stall(1'b0), .i_wb_err(wb_err),
        .i_wb_data(wb_rdata), .i_tx_stb(tx_stb), .i_tx_data(tx_data), .o_tx_busy(tx_busy),
        .o_rx_stb(rx_stb), .o_rx_data(rx_data), .i_rx_busy(rx_busy), .o_rx_err(rx_err),
        .o_bus_err(bus_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    // ---------------- console slave model ----------------
    typedef struct {
        int          stamp;
        logic [1:0]  addr;
        logic        we;
        logic [31:0] data;
    } txn_t;
    txn_t        log_q[$];
    logic [31:0] poll_resp = 32'h0001_0000;
    logic [31:0] rx_word   = 32'h0;
    logic [1:0]  err_addr  = 2'b00;
    logic [1:0]  hold_addr = 2'b00;

    logic        req_seen = 1'b0;
    txn_t        req_t;
    logic        pend = 1'b0;
    int          pend_mode = 0;
    logic [31:0] pend_data = 32'h0;

    always @(negedge clk) begin
        req_seen     = wb_cyc && wb_stb;
        req_t.stamp  = cyc_cnt;
        req_t.addr   = wb_addr;
        req_t.we     = wb_we;
        req_t.data   = wb_wdata;
    end

    always @(posedge clk) begin
        #1;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        if (pend) begin
            pend = 1'b0;
            if (pend_mode == 0) begin
                wb_ack   = 1'b1;
                wb_rdata = pend_data;
            end else if (pend_mode == 1) begin
                wb_err = 1'b1;
            end
        end
        if (req_seen) begin
            log_q.push_back(req_t);
            pend      = 1'b1;
            pend_data = (req_t.addr == 2'b01) ? poll_resp : rx_word;
            pend_mode = (req_t.addr == err_addr) ? 1 : (req_t.addr == hold_addr) ? 2 : 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int scan = 0;

    task automatic wait_addr(input logic [1:0] a, output int idx);
        idx = -1;
        for (int n = 0; n < 300 && idx < 0; n++) begin
            @(negedge clk);
            for (int k = scan; k < log_q.size(); k++)
                if (idx < 0 && log_q[k].addr == a) idx = k;
        end
        if (idx < 0) begin
            $display("FAIL wait_addr: no request to address %0d within 300 cycles", a);
            $fatal(1, "bus request timeout");
        end
        scan = idx + 1;
    endtask

    task automatic at_cycle(input int c);
        while (cyc_cnt < c) @(negedge clk);
    endtask

    task automatic load_tx(input logic [6:0] c);
        @(negedge clk);
        tx_stb  = 1'b1;
        tx_data = c;
        @(negedge clk);
        chk("tx_busy_after_accept", 32'(tx_busy), 32'd1);
        tx_stb  = 1'b0;
        tx_data = 7'($urandom);
    endtask

    // ---------------- stimulus ----------------
    int          rel, s, k, k2, p, a, b, d, nonpoll;
    logic [31:0] w;
    logic [6:0]  c, c2;
    logic        exp_load;

    initial begin
        rst_n   = 1'b0;
        tx_stb  = 1'b0;
        tx_data = 7'h0;
        rx_busy = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_cyc",     32'(wb_cyc),   32'd0);
        chk("rst_stb",     32'(wb_stb),   32'd0);
        chk("rst_we",      32'(wb_we),    32'd0);
        chk("rst_addr",    32'(wb_addr),  32'd0);
        chk("rst_wdata",   wb_wdata,      32'd0);
        chk("rst_tx_busy", 32'(tx_busy),  32'd0);
        chk("rst_rx_stb",  32'(rx_stb),   32'd0);
        chk("rst_rx_data", 32'(rx_data),  32'd0);
        chk("rst_rx_err",  32'(rx_err),   32'd0);
        chk("rst_bus_err", 32'(bus_err),  32'd0);

        // Idle polling: first poll right after release, then every 5+16 cycles.
        rel   = cyc_cnt;
        rst_n = 1'b1;
        wait_addr(2'b01, k);
        chk("first_poll_cycle", 32'(log_q[k].stamp), 32'(rel + 1));
        wait_addr(2'b01, k2);
        chk("poll_period_1", 32'(log_q[k2].stamp - log_q[k].stamp), 32'd21);
        wait_addr(2'b01, k);
        chk("poll_period_2", 32'(log_q[k].stamp - log_q[k2].stamp), 32'd21);
        nonpoll = 0;
        foreach (log_q[i]) if (log_q[i].addr != 2'b01) nonpoll++;
        chk("idle_no_rx_tx", 32'(nonpoll), 32'd0);

        // RX reads with random words: load unless bit 8, rx_err mirrors bit 12.
        for (int it = 0; it < 6; it++) begin
            w      = $urandom;
            w[8]   = ($urandom_range(0, 2) == 0);
            w[12]  = 1'($urandom);
            if (it == 0) w[8] = 1'b0;
            if (it == 1) begin w[8] = 1'b1; w[12] = 1'b1; end
            rx_word  = w;
            exp_load = !w[8];
            scan      = log_q.size();
            poll_resp = 32'h0000_0001;
            wait_addr(2'b10, k);
            s = log_q[k].stamp;
            poll_resp = 32'h0001_0000;
            at_cycle(s + 2);
            chk("rx_stb_before_ack", 32'(rx_stb), 32'd0);
            at_cycle(s + 3);
            chk("rx_stb_after_ack", 32'(rx_stb), 32'(exp_load));
            chk("rx_err_pulse", 32'(rx_err), 32'(w[12]));
            if (exp_load) chk("rx_data", 32'(rx_data), 32'(w[6:0]));
            at_cycle(s + 4);
            chk("rx_err_one_cycle", 32'(rx_err), 32'd0);
            if (exp_load) begin
                repeat (3) @(negedge clk);
                chk("rx_stb_held", 32'(rx_stb), 32'd1);
                chk("rx_data_held", 32'(rx_data), 32'(w[6:0]));
                rx_busy = 1'b0;
                @(negedge clk);
                chk("rx_stb_popped", 32'(rx_stb), 32'd0);
                rx_busy = 1'b1;
            end
        end

        // TX writes with random characters.
        for (int it = 0; it < 3; it++) begin
            c = 7'($urandom);
            scan = log_q.size();
            load_tx(c);
            wait_addr(2'b11, k);
            s = log_q[k].stamp;
            chk("tx_we", 32'(log_q[k].we), 32'd1);
            chk("tx_wdata", log_q[k].data, {25'h0, c});
            at_cycle(s + 2);
            chk("tx_busy_at_ack", 32'(tx_busy), 32'd1);
            at_cycle(s + 3);
            chk("tx_busy_after_ack", 32'(tx_busy), 32'd0);
        end

        // Refill while the holding register empties: not accepted until busy is low.
        c  = 7'($urandom);
        c2 = 7'($urandom);
        scan = log_q.size();
        load_tx(c);
        wait_addr(2'b11, k);
        s = log_q[k].stamp;
        tx_stb  = 1'b1;
        tx_data = c2;
        at_cycle(s + 3);
        chk("refill_not_bypassed", 32'(tx_busy), 32'd0);
        at_cycle(s + 4);
        chk("refill_accepted", 32'(tx_busy), 32'd1);
        tx_stb = 1'b0;
        wait_addr(2'b11, k2);
        chk("refill_write_cycle", 32'(log_q[k2].stamp), 32'(s + 8));
        chk("refill_wdata", log_q[k2].data, {25'h0, c2});
        at_cycle(log_q[k2].stamp + 4);

        // Full service: POLL, RXREAD, TXWRITE, POLL back to back, 4 cycles apart.
        rx_busy   = 1'b0;
        poll_resp = 32'h0;
        c = 7'($urandom);
        load_tx(c);
        rx_word = {$urandom} & 32'hFFFF_EE7F;
        repeat (30) @(negedge clk);
        scan      = log_q.size();
        poll_resp = 32'h0001_0001;
        wait_addr(2'b01, p);
        wait_addr(2'b10, a);
        wait_addr(2'b11, b);
        wait_addr(2'b01, d);
        poll_resp = 32'h0001_0000;
        chk("seq_rx_follows_poll", 32'(a - p), 32'd1);
        chk("seq_tx_follows_rx", 32'(b - a), 32'd1);
        chk("seq_poll_follows_tx", 32'(d - b), 32'd1);
        chk("seq_service_cycles", 32'(log_q[d].stamp - log_q[p].stamp), 32'd12);
        chk("seq_tx_wdata", log_q[b].data, {25'h0, c});
        repeat (40) @(negedge clk);
        rx_busy = 1'b1;

        // Bus error on TXWRITE: abort, keep the character, retry after the interval.
        c = 7'($urandom);
        err_addr = 2'b11;
        scan = log_q.size();
        load_tx(c);
        wait_addr(2'b11, k);
        s = log_q[k].stamp;
        at_cycle(s + 2);
        chk("err_cyc_before", 32'(wb_cyc), 32'd1);
        at_cycle(s + 3);
        chk("err_cyc_dropped", 32'(wb_cyc), 32'd0);
        chk("err_bus_err", 32'(bus_err), 32'd1);
        chk("err_tx_kept", 32'(tx_busy), 32'd1);
        at_cycle(s + 4);
        chk("err_bus_err_pulse", 32'(bus_err), 32'd0);
        err_addr = 2'b00;
        wait_addr(2'b11, k2);
        chk("err_retry_cycle", 32'(log_q[k2].stamp), 32'(s + 24));
        chk("err_retry_wdata", log_q[k2].data, {25'h0, c});
        at_cycle(log_q[k2].stamp + 4);

`ifdef CONSOLE_HOST_TIMEOUT_EN
        // Withheld ack: watchdog aborts after 15 cycles, retry follows the interval.
        c = 7'($urandom);
        hold_addr = 2'b11;
        scan = log_q.size();
        load_tx(c);
        wait_addr(2'b11, k);
        s = log_q[k].stamp;
        at_cycle(s + 14);
        chk("tmo_cyc_held", 32'(wb_cyc), 32'd1);
        at_cycle(s + 15);
        chk("tmo_cyc_dropped", 32'(wb_cyc), 32'd0);
        chk("tmo_bus_err", 32'(bus_err), 32'd1);
        hold_addr = 2'b00;
        wait_addr(2'b11, k2);
        chk("tmo_retry_cycle", 32'(log_q[k2].stamp), 32'(s + 36));
        chk("tmo_retry_wdata", log_q[k2].data, {25'h0, c});
        at_cycle(log_q[k2].stamp + 4);
`endif
        chk("final_tx_empty", 32'(tx_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
